// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundle of the writeback arbiter's request, register-port and hazard-check
// signals.
//   slave  : arbiter side (takes requests, drives the register write port)
//   master : producer / register bank / decode side
// Signals:
//   alu_valid_i/alu_ready_o/alu_addr_i/alu_data_i  ALU write request
//   lsu_valid_i/lsu_ready_o/lsu_addr_i/lsu_data_i  LSU write request
//   wb_stall_i, we_o, waddr_o, wdata_o             register bank write port
//   chk_addr_a_i/b_i, busy_a_o/b_o                 decode hazard check
//   count_o                                        queue occupancy
// -----------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int DATAWIDTH = 32,
  parameter int NUMREGS   = 32,
  parameter int DEPTH     = 4
);
  localparam int AW = $clog2(NUMREGS);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 alu_valid_i;
  logic                 alu_ready_o;
  logic [AW-1:0]        alu_addr_i;
  logic [DATAWIDTH-1:0] alu_data_i;
  logic                 lsu_valid_i;
  logic                 lsu_ready_o;
  logic [AW-1:0]        lsu_addr_i;
  logic [DATAWIDTH-1:0] lsu_data_i;
  logic                 wb_stall_i;
  logic                 we_o;
  logic [AW-1:0]        waddr_o;
  logic [DATAWIDTH-1:0] wdata_o;
  logic [AW-1:0]        chk_addr_a_i;
  logic [AW-1:0]        chk_addr_b_i;
  logic                 busy_a_o;
  logic                 busy_b_o;
  logic [CW-1:0]        count_o;

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  lsu_valid_i, lsu_addr_i, lsu_data_i,
    input  wb_stall_i, chk_addr_a_i, chk_addr_b_i,
    output alu_ready_o, lsu_ready_o,
    output we_o, waddr_o, wdata_o,
    output busy_a_o, busy_b_o, count_o
  );

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output lsu_valid_i, lsu_addr_i, lsu_data_i,
    output wb_stall_i, chk_addr_a_i, chk_addr_b_i,
    input  alu_ready_o, lsu_ready_o,
    input  we_o, waddr_o, wdata_o,
    input  busy_a_o, busy_b_o, count_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Round-robin arbiter between ALU and LSU register writes feeding an in-order
// FIFO that drains one entry per cycle onto the register bank write port.
// Also reports whether decode's source registers have a queued write pending.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : wb_arbiter_if.slave (requests, write port, hazard check, count)
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int NUMREGS   = 32,
  parameter int DEPTH     = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_arbiter_if.slave  bus
);
  localparam int AW = $clog2(NUMREGS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Queue storage; read combinationally at the head and across all entries
  // for the hazard check.
  logic [AW-1:0]        addr_mem [DEPTH];
  logic [DATAWIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          last_grant_reg;  // 0: ALU granted last, 1: LSU granted last

  logic                 full;
  logic                 contended;
  logic                 alu_ready;
  logic                 lsu_ready;
  logic                 alu_xfer;
  logic                 lsu_xfer;
  logic                 push;
  logic                 pop;
  logic [AW-1:0]        push_addr;
  logic [DATAWIDTH-1:0] push_data;

  always_comb begin
    full      = (count_reg == CW'(DEPTH));
    contended = bus.alu_valid_i & bus.lsu_valid_i;
    // Under contention only the source not granted last is ready; otherwise
    // both are ready so a lone requester never waits on the other.
    alu_ready = !full & (!contended |  last_grant_reg);
    lsu_ready = !full & (!contended | !last_grant_reg);
    alu_xfer  = bus.alu_valid_i & alu_ready;
    lsu_xfer  = bus.lsu_valid_i & lsu_ready;
    push_addr = lsu_xfer ? bus.lsu_addr_i : bus.alu_addr_i;
    push_data = lsu_xfer ? bus.lsu_data_i : bus.alu_data_i;
    // Writes to register 0 are accepted but dropped.
    push      = (alu_xfer | lsu_xfer) & (push_addr != '0);
    pop       = (count_reg != '0) & !bus.wb_stall_i;
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      last_grant_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      // Fairness state moves only when a real choice was made.
      if (contended & !full) last_grant_reg <= lsu_xfer;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      addr_mem[wr_ptr_reg] <= push_addr;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  // Hazard check: an entry counts only if it lies within count_reg slots
  // ahead of the read pointer (modulo DEPTH).
  logic [DEPTH-1:0] occupied;
  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] offset;
      assign offset       = PW'(gi) - rd_ptr_reg;
      assign occupied[gi] = ({1'b0, offset} < count_reg);
      assign match_a[gi]  = occupied[gi] & (addr_mem[gi] == bus.chk_addr_a_i);
      assign match_b[gi]  = occupied[gi] & (addr_mem[gi] == bus.chk_addr_b_i);
    end
  endgenerate

  assign bus.alu_ready_o = alu_ready;
  assign bus.lsu_ready_o = lsu_ready;
  assign bus.we_o        = pop;
  assign bus.waddr_o     = (count_reg != '0) ? addr_mem[rd_ptr_reg] : '0;
  assign bus.wdata_o     = (count_reg != '0) ? data_mem[rd_ptr_reg] : '0;
  assign bus.busy_a_o    = (bus.chk_addr_a_i != '0) & (|match_a);
  assign bus.busy_b_o    = (bus.chk_addr_b_i != '0) & (|match_b);
  assign bus.count_o     = count_reg;
endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Table-driven bench for wb_arbiter. Each vector gives the request inputs and
// the expected ready outputs; a scoreboard queue of accepted writes provides
// the expected write-port contents, count and busy flags.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
  localparam int DATAWIDTH = 32;
  localparam int NUMREGS   = 32;
  localparam int DEPTH     = 4;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        lsu_v;
    logic [4:0]  lsu_a;
    logic [31:0] lsu_d;
    logic        stall;
    logic [4:0]  chk_a;
    logic [4:0]  chk_b;
    logic        exp_alu_r;
    logic        exp_lsu_r;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;
  wr_t  sb[$];
  vec_t vecs[$];

  wb_arbiter_if #(.DATAWIDTH(DATAWIDTH), .NUMREGS(NUMREGS), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(.DATAWIDTH(DATAWIDTH), .NUMREGS(NUMREGS), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic st, input logic [4:0] ca, input logic [4:0] cb,
                              input logic ear, input logic elr);
    vec_t v;
    v.alu_v = av; v.alu_a = aa; v.alu_d = ad;
    v.lsu_v = lv; v.lsu_a = la; v.lsu_d = ld;
    v.stall = st; v.chk_a = ca; v.chk_b = cb;
    v.exp_alu_r = ear; v.exp_lsu_r = elr;
    return v;
  endfunction

  function automatic logic busy_model(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (sb[i]) if (sb[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, step_no, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.alu_valid_i  = v.alu_v;
    bus.alu_addr_i   = v.alu_a;
    bus.alu_data_i   = v.alu_d;
    bus.lsu_valid_i  = v.lsu_v;
    bus.lsu_addr_i   = v.lsu_a;
    bus.lsu_data_i   = v.lsu_d;
    bus.wb_stall_i   = v.stall;
    bus.chk_addr_a_i = v.chk_a;
    bus.chk_addr_b_i = v.chk_b;
  endtask

  // One clock cycle: drive just after the rising edge, compare on the
  // falling edge, update the scoreboard, then advance to the next edge.
  task automatic step(input vec_t v);
    logic exp_we;
    wr_t  w;
    drive(v);
    @(negedge clk);
    step_no++;
    exp_we = (sb.size() != 0) && !v.stall;
    $display("step %0d: alu %b a=%0d lsu %b a=%0d stall %b -> rdy %b%b we %b waddr %0d cnt %0d",
             step_no, v.alu_v, v.alu_a, v.lsu_v, v.lsu_a, v.stall,
             bus.alu_ready_o, bus.lsu_ready_o, bus.we_o, bus.waddr_o, bus.count_o);
    check("alu_ready", 64'(bus.alu_ready_o), 64'(v.exp_alu_r));
    check("lsu_ready", 64'(bus.lsu_ready_o), 64'(v.exp_lsu_r));
    check("count",     64'(bus.count_o),     64'(sb.size()));
    check("we",        64'(bus.we_o),        64'(exp_we));
    check("busy_a",    64'(bus.busy_a_o),    64'(busy_model(v.chk_a)));
    check("busy_b",    64'(bus.busy_b_o),    64'(busy_model(v.chk_b)));
    if (sb.size() == 0) begin
      check("waddr_empty", 64'(bus.waddr_o), 64'd0);
      check("wdata_empty", 64'(bus.wdata_o), 64'd0);
    end
    if (exp_we) begin
      w = sb.pop_front();
      check("waddr", 64'(bus.waddr_o), 64'(w.addr));
      check("wdata", 64'(bus.wdata_o), 64'(w.data));
    end
    if (v.alu_v && v.exp_alu_r && v.alu_a != 5'd0) begin
      w.addr = v.alu_a; w.data = v.alu_d; sb.push_back(w);
    end
    if (v.lsu_v && v.exp_lsu_r && v.lsu_a != 5'd0) begin
      w.addr = v.lsu_a; w.data = v.lsu_d; sb.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input vec_t v);
    drive(v);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    $display("reset applied");
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // alu_v a d | lsu_v a d | stall chk_a chk_b | exp ready alu lsu
    // Reset state and single ALU write
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 1));
    // Write to register 0 is handshaken but dropped
    vecs.push_back(mk(0, 0, 0,            1, 0, 32'h1,    0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 1));
    // Contention under stall: LSU, ALU, LSU, ALU, then full
    vecs.push_back(mk(1, 1, 32'hA0,       1, 2, 32'hB0,   1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 32'hA1,       1, 2, 32'hB1,   1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 32'hA2,       1, 2, 32'hB2,   1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 32'hA3,       1, 2, 32'hB3,   1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 32'hA4,       1, 2, 32'hB4,   1, 0, 0, 0, 0));
    // Full with a pop: no pass-through, accepted on the following cycle
    vecs.push_back(mk(1, 9, 32'hA9,       0, 0, 0,        0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 32'hA9,       0, 0, 0,        0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 1));
    // Busy check with entries for 3 and 7
    vecs.push_back(mk(1, 3, 32'h33,       0, 0, 0,        1, 7, 4, 1, 1));
    vecs.push_back(mk(0, 0, 0,            1, 7, 32'h77,   1, 7, 4, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 7, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 7, 4, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 7, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 7, 4, 1, 1));

    foreach (vecs[i]) step(vecs[i]);

    // Reset mid-operation with three entries queued and last grant = LSU
    step(mk(1, 10, 32'hC0, 1, 11, 32'hD0, 1, 10, 11, 0, 1));
    step(mk(1, 12, 32'hC1, 0, 0,  0,      1, 12, 13, 1, 1));
    step(mk(0, 0,  0,      1, 13, 32'hD1, 1, 13, 11, 1, 1));
    do_reset(mk(1, 14, 32'hEE, 1, 15, 32'hFF, 0, 0, 0, 1, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 12, 13, 1, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 11, 10, 1, 1));
    // Last grant must be back to ALU, so contention grants the LSU
    step(mk(1, 20, 32'h20, 1, 21, 32'h21, 1, 21, 20, 0, 1));
    step(mk(0, 0,  0,      0, 0,  0,      0, 21, 20, 1, 1));
    step(mk(0, 0,  0,      0, 0,  0,      0, 21, 20, 1, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and queue for the register bank write port. It accepts register write requests from two producers: the ALU and the load/store unit (LSU). Requests are arbitrated round-robin into an in-order FIFO, and the FIFO drains one entry per cycle onto the register bank's single write port. The block sits between the execute/memory stages and the register bank. It also tells decode which source registers still have a write pending in the queue.

## Interface
- DATAWIDTH, 32, data width of a register write
- NUMREGS, 32, number of architectural registers; address width is $clog2(NUMREGS)
- DEPTH, 4, queue entries; power of two, at least 2

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock, all state updates on the rising edge
- rst_i  in  1  synchronous active-high reset
- alu_valid_i  in  1  ALU write request valid
- alu_ready_o  out  1  ALU request accepted this cycle when high together with valid
- alu_addr_i  in  $clog2(NUMREGS)  ALU destination register
- alu_data_i  in  DATAWIDTH  ALU write data
- lsu_valid_i  in  1  LSU write request valid
- lsu_ready_o  out  1  LSU request accepted this cycle when high together with valid
- lsu_addr_i  in  $clog2(NUMREGS)  LSU destination register
- lsu_data_i  in  DATAWIDTH  LSU write data
- wb_stall_i  in  1  register write port unavailable this cycle; hold the queue head
- we_o  out  1  register bank write enable
- waddr_o  out  $clog2(NUMREGS)  register bank write address
- wdata_o  out  DATAWIDTH  register bank write data
- chk_addr_a_i  in  $clog2(NUMREGS)  decode source A address to check
- chk_addr_b_i  in  $clog2(NUMREGS)  decode source B address to check
- busy_a_o  out  1  a queued entry targets chk_addr_a_i
- busy_b_o  out  1  a queued entry targets chk_addr_b_i
- count_o  out  $clog2(DEPTH)+1  number of occupied entries

## Operation

State:
- Circular FIFO with DEPTH entries of {addr, data}.
- Write pointer, read pointer and count.
- One last-grant bit: 0 = ALU was last granted, 1 = LSU was last granted.

Arbitration (at most one enqueue per cycle):
- FIFO full (count == DEPTH): both ready outputs are 0.
- Only one source valid: that source's ready is 1.
- Both sources valid: grant goes to the source not last granted, and only its ready is 1.
- Neither source valid: both ready outputs are 1; they are don't-care for the handshake.
- The last-grant bit updates only on a contended grant, meaning both sources were valid and the queue was not full.
- A transfer occurs when valid & ready.
- Address 0: a transfer with addr == 0 is handshaken but not enqueued. count, the pointers and the busy outputs are unchanged.

Drain:
- we_o = (count != 0) & !wb_stall_i.
- waddr_o and wdata_o present the head entry while count != 0, and are 0 when the queue is empty.
- A pop occurs on every rising edge where we_o = 1.

Simultaneous push and pop:
- Push and pop may occur in the same edge; count is then unchanged.
- When the queue is full and a pop occurs, ready is still 0 that cycle. There is no pass-through.

Ordering and hazard check:
- Entries drain strictly in acceptance order, so two writes to the same register retire in order.
- busy_x_o = 1 iff chk_addr_x_i != 0 and some occupied entry has that addr.
- The busy check is combinational over occupied entries only. It does not include the request being accepted this cycle.

Reset:
- Pointers, count and last-grant bit are cleared; last-grant resets to ALU, so the first contended cycle grants the LSU.
- Outputs in the cycle after rst_i: we_o = 0, waddr_o = 0, wdata_o = 0, count_o = 0, busy_a_o = 0, busy_b_o = 0, alu_ready_o = 1, lsu_ready_o = 1.
- Reset mid-operation discards all queued entries; no write is issued in the reset cycle.
- rst_i has priority over all handshakes.

## Timing
- An entry accepted at edge N can drive we_o in cycle N+1 at the earliest, provided the queue was empty and wb_stall_i is low. Minimum latency is 1 cycle.
- Throughput is one accept and one retire per cycle.
- A queue holding k entries ahead of a request delays it by k non-stalled cycles.
- ready outputs depend combinationally on both valid inputs, count and the last-grant bit; they do not depend on data.
- we_o, waddr_o, wdata_o and busy_x_o are combinational from the registered queue state, plus wb_stall_i for we_o and chk_addr_x_i for busy_x_o.
- count_o is registered.

## Test plan
- Single write: ALU writes addr 5, data 0xDEADBEEF, into an empty queue -> alu_ready_o = 1; next cycle we_o = 1, waddr_o = 5, wdata_o = 0xDEADBEEF; the cycle after that, we_o = 0 and count_o = 0.
- Contention: both sources valid for 4 cycles with wb_stall_i = 1 -> grant order LSU, ALU, LSU, ALU; count_o reaches 4 and both ready outputs go to 0; after wb_stall_i is released, the entries drain in that order, one per cycle.
- Full with simultaneous pop: fill 4 entries under stall, release stall while ALU is valid -> the ALU is not accepted in the pop cycle and is accepted in the next cycle; count_o goes 4, 3, 3.
- Address 0: LSU writes addr 0, data 0x1 -> lsu_ready_o = 1, count_o stays 0, we_o is never asserted.
- Busy check: queue entries for addr 3 and addr 7 under stall, with chk_addr_a_i = 7 and chk_addr_b_i = 4 -> busy_a_o = 1 and busy_b_o = 0; after both entries drain, busy_a_o = 0. Also check chk_addr_a_i = 0 -> busy_a_o = 0.
- Reset mid-operation: assert rst_i with 3 entries queued -> next cycle count_o = 0, we_o = 0, and both ready outputs = 1; no stale entry is ever written afterwards.
